// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin merge of NUM_SRC AXI-Stream sources onto one registered m00 port.
// Define AXIS_ARB_PKT_CNT_EN to enable the completed-packet counter on pkt_count.
module axis_rr_arbiter #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned NUM_SRC   = 4
) (
    input  logic                           m00_axis_aclk,
    input  logic                           m00_axis_aresetn,
    input  logic                           arb_enable,
    input  logic [NUM_SRC*DATA_SIZE-1:0]   s_axis_tdata,
    input  logic [NUM_SRC*DATA_SIZE/8-1:0] s_axis_tstrb,
    input  logic [NUM_SRC-1:0]             s_axis_tvalid,
    input  logic [NUM_SRC-1:0]             s_axis_tlast,
    output logic [NUM_SRC-1:0]             s_axis_tready,
    output logic [DATA_SIZE-1:0]           m00_axis_tdata,
    output logic [DATA_SIZE/8-1:0]         m00_axis_tstrb,
    output logic                           m00_axis_tvalid,
    input  logic                           m00_axis_tready,
    output logic                           m00_axis_tlast,
    output logic [NUM_SRC-1:0]             grant,
    output logic [15:0]                    pkt_count
);

    localparam int unsigned STRB_SIZE = DATA_SIZE / 8;
    localparam int unsigned IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [DATA_SIZE-1:0] tdata_q, tdata_d;
    logic [STRB_SIZE-1:0] tstrb_q, tstrb_d;
    logic                 tlast_q, tlast_d;
    logic                 tvalid_q, tvalid_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [DATA_SIZE-1:0] sel_tdata;
    logic [STRB_SIZE-1:0] sel_tstrb;
    logic                 sel_tlast;
    logic                 sel_tvalid;
    logic                 out_ready;
    logic                 in_ready;
    logic                 accept;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] base,
                                                 input int unsigned step);
        int unsigned idx;
        idx = (32'(base) + step) % NUM_SRC;
        return idx[IDX_W-1:0];
    endfunction

    // First requester after the previous owner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            if (!win_found && s_axis_tvalid[rr_next(last_q, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_next(last_q, k);
            end
        end
    end

    always_comb begin
        sel_tdata  = '0;
        sel_tstrb  = '0;
        sel_tlast  = 1'b0;
        sel_tvalid = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
                sel_tdata  = s_axis_tdata[i*DATA_SIZE +: DATA_SIZE];
                sel_tstrb  = s_axis_tstrb[i*STRB_SIZE +: STRB_SIZE];
                sel_tlast  = s_axis_tlast[i];
                sel_tvalid = s_axis_tvalid[i];
            end
        end
    end

    // The output register can take a new beat when empty or draining this cycle.
    assign out_ready     = ~tvalid_q | m00_axis_tready;
    assign in_ready      = (state_q == ST_XFER) & out_ready;
    assign accept        = in_ready & sel_tvalid;
    assign s_axis_tready = grant_q & {NUM_SRC{in_ready}};

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        last_d   = last_q;
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;

        if (tvalid_q && m00_axis_tready) begin
            tvalid_d = 1'b0;
        end
        if (accept) begin
            tdata_d  = sel_tdata;
            tstrb_d  = sel_tstrb;
            tlast_d  = sel_tlast;
            tvalid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_enable && win_found) begin
                    state_d = ST_XFER;
                    grant_d = NUM_SRC'(1) << win_idx;
                    owner_d = win_idx;
                end
            end
            ST_XFER: begin
                if (accept && sel_tlast) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            last_q   <= IDX_W'(NUM_SRC - 1);
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            tdata_q  <= tdata_d;
            tstrb_q  <= tstrb_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tstrb  = tstrb_q;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tvalid = tvalid_q;
    assign grant           = grant_q;

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [15:0] pkt_count_q;

    // Counts packets leaving on m00, wrapping naturally at 16 bits.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            pkt_count_q <= 16'd0;
        end else if (tvalid_q && m00_axis_tready && tlast_q) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`else
    assign pkt_count = 16'd0;
`endif

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter that merges NUM_SRC AXI-Stream generator outputs onto one AXI-Stream master port (m00).
- Ownership switches only on packet boundaries (tlast). Packets are never interleaved.
- Sits between the bank of stream generators and the single downstream consumer.
- Provides a global enable and per-source grant visibility.

Parameters:
- DATA_SIZE, 32, tdata width in bits (multiple of 8).
- NUM_SRC, 4, number of slave stream inputs (2..8).

Ports:
- m00_axis_aclk  input  1  sole clock, rising edge.
- m00_axis_aresetn  input  1  asynchronous active-low reset.
- arb_enable  input  1  1 = new grants allowed; 0 = finish current packet, then hold idle.
- s_axis_tdata  input  NUM_SRC*DATA_SIZE  packed source data; source i occupies [i*DATA_SIZE +: DATA_SIZE].
- s_axis_tstrb  input  NUM_SRC*DATA_SIZE/8  packed byte strobes.
- s_axis_tvalid  input  NUM_SRC  per-source valid.
- s_axis_tlast  input  NUM_SRC  per-source last.
- s_axis_tready  output  NUM_SRC  per-source ready; at most one bit high at a time.
- m00_axis_tdata  output  DATA_SIZE  merged data.
- m00_axis_tstrb  output  DATA_SIZE/8  merged strobes.
- m00_axis_tvalid  output  1  merged valid.
- m00_axis_tready  input  1  downstream ready.
- m00_axis_tlast  output  1  merged last.
- grant  output  NUM_SRC  one-hot current owner; 0 when idle.
- pkt_count  output  16  completed packets sent on m00 (optional feature).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-packet):
  - All outputs 0.
  - State = IDLE.
  - Round-robin pointer last = NUM_SRC-1, so source 0 wins first.
  - Any partially transferred packet is abandoned.
- FSM states:
  - IDLE: grant=0, s_axis_tready=0. If arb_enable=1 and any s_axis_tvalid=1, pick the winner at the clock edge: first index with tvalid=1 searching last+1, last+2, … modulo NUM_SRC. grant <= onehot(winner); next state XFER. Otherwise stay in IDLE.
  - XFER: s_axis_tready[g] = (~m00_axis_tvalid | m00_axis_tready); all other tready bits are 0.
    - Input beat accepted (tvalid[g] & tready[g]): load the output register with tdata, tstrb and tlast of source g; m00_axis_tvalid <= 1.
    - Accepted beat has tlast=1: next state IDLE, grant <= 0, last <= g.
- Output register:
  - One-cycle latency from input handshake to m00 presentation.
  - Full throughput while m00_axis_tready=1.
  - While m00_axis_tvalid=1 and m00_axis_tready=0, m00 data, strb and last hold stable and s_axis_tready[g]=0.
  - m00_axis_tvalid clears when a beat is taken and no new input beat is accepted in the same cycle.
- Packet gap: exactly one IDLE cycle between the last beat of one packet and the first accept of the next.
- arb_enable fall mid-packet: the current packet completes normally; no new grant until arb_enable=1.
- tvalid low mid-packet on the owning source: the grant is held indefinitely. There is no timeout and no preemption.
- Sources without a grant see tready=0 regardless of their tvalid.
- A single-beat packet (tvalid and tlast together on the first beat) is legal: one beat, then IDLE.
- Simultaneous output drain and input accept in the same cycle: the output register is overwritten with the new beat and tvalid stays 1.

Optional Feature:
- Macro: AXIS_ARB_PKT_CNT_EN.
- Defined:
  - pkt_count increments by 1 on each m00 handshake with m00_axis_tlast=1.
  - 16-bit counter, wraps 65535 -> 0.
  - Reset to 0.
- Undefined: pkt_count tied to 0; no counter logic.

Test Plan:
- Single source: s0 sends a 3-beat packet 0x11,0x22,0x33 (tlast on 0x33), m00_axis_tready=1 -> m00 shows 0x11,0x22,0x33 on consecutive cycles, tlast on 0x33; grant=0001 during the packet, then 0000; pkt_count=1.
- All four sources valid with 2-beat packets from reset -> service order s0,s1,s2,s3,s0; no interleaving within packets; one idle cycle between packets.
- Backpressure: m00_axis_tready toggles 1,0,0,1 during s2's 4-beat packet -> m00_axis_tdata stable while tready=0; no beat lost or duplicated; s_axis_tready[2]=0 during the stall.
- arb_enable dropped in the middle of s1's 5-beat packet, with s3 also valid -> all 5 beats of s1 delivered; no grant to s3 until arb_enable returns to 1, then s3 is served.
- Reset asserted mid-packet (after beat 2 of 4) -> all outputs 0 immediately; after release, s0 is granted first and pkt_count=0.
- With AXIS_ARB_PKT_CNT_EN defined, drive 65537 single-beat packets -> pkt_count=1 at the end (wrap).
